// File: rtl/uart_ext.sv
// uart_ext: serial console expansion card on the shared 16-bit bus.
//   RX: 2-flop synchronised UART receiver feeding a DEPTH-entry byte FIFO.
//   TX: single holding register transmitter, built only with UART_EXT_TX_EN
//       defined; otherwise tx idles high and TXDATA writes are ignored.
// Ports:
//   clk    system clock, all state on the rising edge
//   r      synchronous active-high reset
//   bus    shared data bus, driven only while oe=1
//   addro  address, only addro[1:0] decoded (0 DATA, 1 STATUS, 2 TXDATA, 3 DIV)
//   we/oe  port write strobe / output enable
//   rx/tx  serial in (asynchronous, idle high) / serial out (idle high)
//   irq    high while the RX FIFO is non-empty
module uart_ext #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_RESET = 103
) (
  input  logic        clk,
  input  logic        r,
  inout  wire  [15:0] bus,
  input  logic [23:0] addro,
  input  logic        we,
  input  logic        oe,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [1:0]    sel;
  logic          unused_addr;
  logic [15:0]   rd_data;
  logic          tx_busy;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [15:0]   div_q, div_d;
  logic          oe_q, oe_d;
  logic [1:0]    sel_q, sel_d;
  logic          ovr_q, ovr_d, fe_q, fe_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic push_req, fe_set, pop, do_push, full, nonempty, stat_wr;

  assign sel         = addro[1:0];
  assign unused_addr = ^addro[23:2];
  assign full        = (count_q == CW'(DEPTH));
  assign nonempty    = (count_q != '0);
  assign irq         = nonempty;
  assign stat_wr     = we && (sel == 2'd1);
  // Pop on the falling edge of oe after a DATA read, so a held read pops once.
  assign pop         = oe_q && !oe && (sel_q == 2'd0) && nonempty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push     = push_req && (!full || pop);

  // RX receiver
  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    push_req   = 1'b0;
    fe_set     = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = div_q >> 1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = div_q;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) push_req = 1'b1;
          else         fe_set   = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO, flags and register writes
  always_comb begin
    oe_d     = oe;
    sel_d    = sel;
    div_d    = (we && sel == 2'd3) ? bus : div_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop)      count_d = count_q + CW'(1);
    else if (!do_push && pop) count_d = count_q - CW'(1);
    // Clear first so that a flag being set in the same cycle wins.
    ovr_d = (stat_wr && bus[2]) ? 1'b0 : ovr_q;
    fe_d  = (stat_wr && bus[3]) ? 1'b0 : fe_q;
    if (push_req && full && !pop) ovr_d = 1'b1;
    if (fe_set)                   fe_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      div_q      <= DIV_INIT;
      oe_q       <= 1'b0;
      sel_q      <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      div_q      <= div_d;
      oe_q       <= oe_d;
      sel_q      <= sel_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!r && do_push) mem_q[wr_ptr_q] <= rx_sh_q;
  end

`ifdef UART_EXT_TX_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == '0) ? div_q : tx_cnt_q - 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = tx_cnt_q;
        if (we && sel == 2'd2) begin
          tx_state_d = TX_START;
          tx_cnt_d   = div_q;
          tx_sh_d    = bus[7:0];
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE);
`else
  assign tx      = 1'b1;
  assign tx_busy = 1'b0;
`endif

  // Read mux, decoded from the live address
  always_comb begin
    rd_data = '0;
    unique case (sel)
      2'd0: rd_data = nonempty ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
      2'd1: rd_data = {8'(count_q), 3'b000, tx_busy, fe_q, ovr_q, full, nonempty};
      2'd2: rd_data = '0;
      2'd3: rd_data = div_q;
      default: rd_data = '0;
    endcase
  end

  assign bus = oe ? rd_data : 'z;
endmodule
